// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Registered N-to-1 datapath mux with an internal arbiter. Several producers
//   share one consumer through valid/ready handshakes; a single output register
//   stage gives one cycle of latency at one word per cycle.
//
// Parameters
//   WIDTH    data bits per channel
//   NUM_CH   number of input channels (2..16)
//   RR_MODE  1 = round-robin, 0 = fixed priority (lowest index wins)
//   SEL_W    width of out_sel, derived from NUM_CH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel request
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected data
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  output register holds valid data
//   out_ready  consumer accepts out_data
module rr_mux_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 1,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  base;
  logic [SEL_W-1:0]  win_idx;
  logic [SEL_W-1:0]  ptr_next;
  logic              found;
  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [WIDTH-1:0]  win_data;

  // Output register can take a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Fixed-priority mode is round-robin scanning from a pointer pinned at 0.
  assign base = (RR_MODE != 0) ? ptr : '0;

  // Scan upward from base, wrapping at NUM_CH-1 (not at 2^SEL_W-1).
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = idx[SEL_W-1:0];
      if (!found && in_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    grant          = '0;
    grant[win_idx] = found;
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (win_idx == SEL_W'(k)) win_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // rst_n gates in_ready so nothing looks accepted while reset is held.
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = |in_ready;
  assign ptr_next = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_data  <= win_data;
        out_sel   <= win_idx;
        out_valid <= 1'b1;
        if (RR_MODE != 0) ptr <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;

  // Shared stimulus for a 4-channel round-robin (a) and fixed-priority (b) DUT.
  logic [31:0]  dat [4];
  logic [127:0] ab_data;
  logic [3:0]   ab_valid;
  logic         ab_ordy;
  logic [3:0]   a_ready, b_ready;
  logic [31:0]  a_od, b_od;
  logic [1:0]   a_sel, b_sel;
  logic         a_ov, b_ov;

  // 3-channel round-robin DUT (c).
  logic [31:0]  cdat [3];
  logic [95:0]  c_data;
  logic [2:0]   c_valid;
  logic         c_ordy;
  logic [2:0]   c_ready;
  logic [31:0]  c_od;
  logic [1:0]   c_sel;
  logic         c_ov;

  int checks;
  int failures;
  logic [33:0] qa[$];
  logic [33:0] qb[$];
  logic [33:0] qc[$];

  assign ab_data = {dat[3], dat[2], dat[1], dat[0]};
  assign c_data  = {cdat[2], cdat[1], cdat[0]};

  rr_mux_arbiter #(.WIDTH(32), .NUM_CH(4), .RR_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(ab_data), .in_valid(ab_valid),
    .in_ready(a_ready), .out_data(a_od), .out_sel(a_sel), .out_valid(a_ov),
    .out_ready(ab_ordy));

  rr_mux_arbiter #(.WIDTH(32), .NUM_CH(4), .RR_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(ab_data), .in_valid(ab_valid),
    .in_ready(b_ready), .out_data(b_od), .out_sel(b_sel), .out_valid(b_ov),
    .out_ready(ab_ordy));

  rr_mux_arbiter #(.WIDTH(32), .NUM_CH(3), .RR_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .out_data(c_od), .out_sel(c_sel), .out_valid(c_ov),
    .out_ready(c_ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Drive one cycle on a/b, check grants before the edge, outputs after it.
  task automatic step(input logic [3:0] v, input logic ordy,
                      input logic [3:0] ea, input logic [3:0] eb);
    logic [33:0] e;
    ab_valid = v;
    ab_ordy  = ordy;
    #1;
    chk("a_in_ready", a_ready, ea);
    chk("b_in_ready", b_ready, eb);
    if (ea != 0) qa.push_back({2'(oh2i(ea)), dat[oh2i(ea)]});
    if (eb != 0) qb.push_back({2'(oh2i(eb)), dat[oh2i(eb)]});
    @(posedge clk); #1;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk("a_out_valid", a_ov, 1);
      chk("a_out_word", {a_sel, a_od}, e);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk("b_out_valid", b_ov, 1);
      chk("b_out_word", {b_sel, b_od}, e);
    end
  endtask

  task automatic step_c(input logic [2:0] v, input logic [2:0] ec);
    logic [33:0] e;
    c_valid = v;
    c_ordy  = 1'b1;
    #1;
    chk("c_in_ready", c_ready, ec);
    if (ec != 0) qc.push_back({2'(oh2i({1'b0, ec})), cdat[oh2i({1'b0, ec})]});
    @(posedge clk); #1;
    if (qc.size() != 0) begin
      e = qc.pop_front();
      chk("c_out_valid", c_ov, 1);
      chk("c_out_word", {c_sel, c_od}, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ab_valid = '0;
    c_valid  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ab_ordy  = 1'b1;
    c_ordy   = 1'b1;
    ab_valid = 4'b1111;
    c_valid  = 3'b111;
    for (int i = 0; i < 4; i++) dat[i] = 32'(i + 1);
    for (int i = 0; i < 3; i++) cdat[i] = 32'hC0 + 32'(i);
    #2;
    chk("rst_a_in_ready", a_ready, 0);
    chk("rst_c_in_ready", c_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ab_valid = '0;
    c_valid  = '0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_out_sel", a_sel, 0);
    chk("rst_a_out_data", a_od, 0);
    chk("rst_c_out_valid", c_ov, 0);

    // Single channel request.
    dat[2] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b1, 4'b0100, 4'b0100);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000);
    chk("drain_a_out_valid", a_ov, 0);
    chk("drain_a_out_data_hold", a_od, 32'hDEAD_BEEF);
    chk("drain_a_out_sel_hold", a_sel, 2);

    // Fairness from a fresh pointer; b stays on channel 0.
    do_reset();
    dat[2] = 32'd3;
    step(4'b1111, 1'b1, 4'b0001, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010, 4'b0001);
    step(4'b1111, 1'b1, 4'b0100, 4'b0001);
    step(4'b1111, 1'b1, 4'b1000, 4'b0001);
    step(4'b1111, 1'b1, 4'b0001, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010, 4'b0001);

    // Backpressure: a holds ch1 word, b holds ch0 word, pointer of a at 2.
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 1'b0, 4'b0000, 4'b0000);
      chk("stall_a_out_valid", a_ov, 1);
      chk("stall_a_out_word", {a_sel, a_od}, {2'd1, 32'd2});
      chk("stall_b_out_word", {b_sel, b_od}, {2'd0, 32'd1});
    end
    step(4'b0011, 1'b1, 4'b0001, 4'b0001);
    step(4'b0011, 1'b1, 4'b0010, 4'b0001);
    step(4'b0011, 1'b1, 4'b0001, 4'b0001);

    // Asynchronous reset between edges while streaming.
    ab_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_a_out_valid", a_ov, 0);
    chk("areset_b_out_valid", b_ov, 0);
    chk("areset_a_out_data", a_od, 0);
    chk("areset_a_in_ready", a_ready, 0);
    #2;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, 4'b0001);
    step(4'b0000, 1'b1, 4'b0000, 4'b0000);

    // Three channels: pointer wraps at 2, out_sel never 3.
    step_c(3'b010, 3'b010);
    step_c(3'b011, 3'b001);
    step_c(3'b011, 3'b010);
    step_c(3'b100, 3'b100);
    step_c(3'b111, 3'b001);
    step_c(3'b000, 3'b000);
    chk("c_drain_out_valid", c_ov, 0);
    chk("c_out_sel_range", (c_sel <= 2'd2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised, registered N-to-1 datapath mux that replaces hand-selected 2-to-1 muxes wherever several producers share one consumer, e.g. instruction-fetch and data-access requests sharing a single memory port.
- Selection is made internally by an arbiter (round-robin or fixed priority), not by an external select line.
- Each side uses a valid/ready handshake; one output register stage gives one cycle of latency at full throughput.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_CH, 2, number of input channels; legal range 2..16.
- RR_MODE, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_CH), derived localparam; width of out_sel (not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer = 0 (channel 0 has highest priority first).
  - in_ready = 0 while reset is asserted.
- Load enable: load_en = !out_valid || out_ready. The output register may accept new data when it is empty or being drained in the same cycle.
- Arbitration (combinational, every cycle):
  - RR_MODE=1: the winner is the first asserted in_valid scanning upward from the pointer, wrapping from NUM_CH-1 to 0.
  - RR_MODE=0: the winner is the lowest-index asserted in_valid; the pointer is unused and stays 0.
- in_ready[i] = load_en && (i == winner) && in_valid[i]. At most one bit is set. in_ready is zero when no channel is valid.
- Transfer on channel i occurs at a rising edge where in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel i data, out_sel <= i, out_valid <= 1.
  - RR_MODE=1: pointer <= i+1, wrapping NUM_CH-1 to 0.
- Drain without refill: out_valid && out_ready with no input transfer → out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and refill in the same edge → out_valid stays 1 and the new data replaces the old. Sustained throughput is one word per cycle.
- Stall: out_valid && !out_ready → out_data, out_sel, out_valid and the pointer hold; all in_ready are 0.
- Pointer advances only on an accepted transfer, never on idle or stalled cycles.
- Latency: input transfer at edge N → out_valid high after edge N.
- Producer rules: in_valid must not depend combinationally on in_ready. Once in_valid[i] is raised, channel i data is held stable until its transfer. in_ready must not depend combinationally on out_valid of the downstream consumer beyond out_ready.
- Reset mid-operation: a pending out_valid word is discarded and the pointer returns to 0. No transfer is recorded on the edge where rst_n is low.
- NUM_CH not a power of two: out_sel never exceeds NUM_CH-1, and the pointer wraps at NUM_CH-1, not at 2^SEL_W-1.

Test Plan:
- Reset and single channel: WIDTH=32, NUM_CH=4. Assert rst_n low, then release; check out_valid=0, out_sel=0, out_data=0. Drive in_valid=4'b0100 with ch2=32'hDEAD_BEEF and out_ready=1 → in_ready=4'b0100 in the same cycle; next cycle out_data=32'hDEAD_BEEF, out_sel=2, out_valid=1.
- Round-robin fairness: RR_MODE=1, NUM_CH=4, all in_valid=4'b1111 held, out_ready=1, ch i data=i+1 → out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Fixed priority: RR_MODE=0, same stimulus → out_sel=0 every cycle; ch1..3 in_ready never asserted.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles and in_valid=4'b0011 → out_data and out_sel stable, in_ready=0 throughout. Release out_ready → next grant goes to the pointer-next channel, and exactly one word is transferred per cycle afterwards.
- Wrap with NUM_CH=3: pointer at 2, in_valid=3'b011 → channel 0 is granted, out_sel=0, and the pointer becomes 1. out_sel never reads 3.
- Asynchronous reset mid-stream: while streaming data with out_valid=1, pulse rst_n low between clock edges → out_valid drops immediately without waiting for a clock edge. After release, the first grant with in_valid=4'b1111 goes to channel 0.
